// File: rtl/mmio_responder.sv
// Uncached I/O target: scratch registers, 64-bit timer with compare interrupt,
// and a byte TX FIFO drained to a serial transmitter. One request in flight.
module mmio_responder #(
  parameter int         TX_DEPTH   = 4,
  parameter logic [9:0] REGION_TAG = 10'h1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        timer_irq,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data
);

  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(TX_DEPTH);

  // Handshake: a channel transfers on a rising edge where its valid and ready
  // are both high; a response, once valid, holds rdata/err stable until taken.
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;
  state_t state_q, state_d;

  logic [63:0] timer_q, cmp_q;
  logic [31:0] scratch0_q, scratch1_q, shadow_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d, irq_q;
  logic [7:0]  fifo_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0] count_q;
  logic        accept, fifo_full, do_push, do_pop;
  logic        wr_s0, wr_s1, wr_clo, wr_chi, rd_tlo, clr_irq, push;
  logic [21:0] offset;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = st[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = req_valid & req_ready;
  assign offset    = req_addr[21:0];
  assign fifo_full = (count_q == FULL_LEVEL);

  // Side-effect flags are raised only for legal accesses, so an error never
  // touches state.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    wr_s0   = 1'b0;
    wr_s1   = 1'b0;
    wr_clo  = 1'b0;
    wr_chi  = 1'b0;
    rd_tlo  = 1'b0;
    clr_irq = 1'b0;
    push    = 1'b0;
    if (req_addr[31:22] != REGION_TAG || req_addr[1:0] != 2'b00) begin
      err_d = 1'b1;
    end else begin
      case (offset)
        22'h00: if (req_write) wr_s0 = 1'b1; else rdata_d = scratch0_q;
        22'h04: if (req_write) wr_s1 = 1'b1; else rdata_d = scratch1_q;
        22'h08: begin
          if (req_write) err_d = 1'b1;
          else begin
            rdata_d = timer_q[31:0];
            rd_tlo  = 1'b1;
          end
        end
        22'h0C: if (req_write) err_d = 1'b1; else rdata_d = shadow_q;
        22'h10: if (req_write) wr_clo = 1'b1; else rdata_d = cmp_q[31:0];
        22'h14: if (req_write) wr_chi = 1'b1; else rdata_d = cmp_q[63:32];
        22'h18: begin
          if (req_write) clr_irq = req_wstrb[0] & req_wdata[0];
          else           rdata_d = {31'b0, irq_q};
        end
        22'h1C: begin
          // Fullness is judged before any same-cycle pop frees a slot.
          if (req_write) begin
            if (fifo_full && req_wstrb != 4'b0000) err_d = 1'b1;
            else                                   push  = req_wstrb[0];
          end
        end
        22'h20: if (req_write) err_d = 1'b1; else rdata_d = 32'(count_q);
        default: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch0_q <= '0;
      scratch1_q <= '0;
      shadow_q   <= '0;
      cmp_q      <= '1;
    end else if (accept) begin
      if (wr_s0)  scratch0_q    <= merge(scratch0_q, req_wdata, req_wstrb);
      if (wr_s1)  scratch1_q    <= merge(scratch1_q, req_wdata, req_wstrb);
      if (wr_clo) cmp_q[31:0]   <= merge(cmp_q[31:0], req_wdata, req_wstrb);
      if (wr_chi) cmp_q[63:32]  <= merge(cmp_q[63:32], req_wdata, req_wstrb);
      if (rd_tlo) shadow_q      <= timer_q[63:32];
    end
  end

  // A compare hit on the same edge as a W1C keeps the interrupt pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      timer_q <= timer_q + 64'd1;
      if (timer_q == cmp_q)          irq_q <= 1'b1;
      else if (accept && clr_irq)    irq_q <= 1'b0;
    end
  end

  assign timer_irq = irq_q;

  assign do_push  = accept & push;
  assign do_pop   = tx_valid & tx_ready;
  assign tx_valid = (count_q != '0);
  assign tx_data  = tx_valid ? fifo_q[rd_ptr_q] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < TX_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      if (do_push) begin
        fifo_q[wr_ptr_q] <= req_wdata[7:0];
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
